// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : shared types and constants for the load/store unit         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    FIN      = 2'd3
  } lsu_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads; stores accept B/H/W.
  function automatic logic op_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (opcode == OP_LOAD) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end else if (opcode == OP_STORE) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// +----------------------------------------------------------------------+
// | lsu_load_align : lane select and sign/zero extension of load data    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{off, 3'b000} +: 8];
    w_half = off[1] ? word[XLEN-1:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_BU:   data = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   data = {{(XLEN-16){1'b0}}, w_half};
      default: data = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// +----------------------------------------------------------------------+
// | lsu_mem_ctrl : load/store controller on a req/gnt/rsp memory bus     |
// | Option: MISALIGN_TRAP_EN traps misaligned accesses instead of        |
// |         truncating the address to natural alignment.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_mem_ctrl #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rd_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  import lsu_pkg::*;

  lsu_state_t      r_state;
  lsu_state_t      w_state_nxt;

  logic            r_err;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [BE_W-1:0] r_mem_be;
  logic [XLEN-1:0] r_rd_data;

  logic            w_legal;
  logic            w_trap;
  logic            w_is_load;
  logic [1:0]      w_off;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_ext;
  logic            w_capture;

  // Truncated offset keeps the lane math consistent whether or not misaligned ops trap.
  always_comb begin
    w_legal   = op_legal(opcode, funct3);
    w_is_load = (opcode == OP_LOAD);
    case (funct3[1:0])
      2'b00: begin
        w_off   = addr[1:0];
        w_be    = BE_W'(1) << w_off;
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_off   = {addr[1], 1'b0};
        w_be    = BE_W'(3) << w_off;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = {BE_W{1'b1}};
        w_wdata = store_data;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    w_trap = ((funct3[1:0] == 2'b01) && addr[0]) ||
             ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    w_trap = 1'b0;
`endif
  end

  assign w_capture = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (!w_legal || w_trap) ? FIN : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          w_state_nxt = r_mem_we ? FIN : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          w_state_nxt = FIN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rd_data   <= '0;
    end else begin
      if (w_capture) begin
        r_err    <= !w_legal || w_trap;
        r_funct3 <= funct3;
        r_off    <= w_off;
        if (w_legal && !w_trap) begin
          r_mem_we    <= !w_is_load;
          r_mem_addr  <= {addr[XLEN-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_is_load ? '0 : w_wdata;
        end
      end
      if ((r_state == WAIT_RSP) && mem_rvalid) begin
        r_rd_data <= w_load_ext;
      end
    end
  end

  lsu_load_align u_load_align (
    .funct3 (r_funct3),
    .off    (r_off),
    .word   (mem_rdata),
    .data   (w_load_ext)
  );

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign err       = (r_state == FIN) && r_err;
  assign rd_data   = r_rd_data;
  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store memory controller on the execute-to-memory boundary.
- Consumes the effective address computed by the ALU from the load/store operand path (RS1 + sign-extended IMM12).
- Issues one request per load/store on a request/grant/response memory bus, formats store lanes and byte enables, and returns aligned, sign- or zero-extended load data for register writeback.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- BE_W, XLEN/8, number of byte-enable bits.

Ports:
- CLK  input  1  core clock; all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle strobe: execute stage presents a memory op.
- OPCODE  input  7  7'b0000011 load, 7'b0100011 store; others illegal.
- FUNCT3  input  3  access size/sign.
- ADDR  input  XLEN  effective address (ALU result).
- STORE_DATA  input  XLEN  RS2 value for stores.
- BUSY  output  1  operation in flight; START ignored while high.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  valid with DONE: illegal op or misaligned.
- RD_DATA  output  XLEN  extended load result; valid with DONE on loads.
- MEM_REQ  output  1  request valid; held until MEM_GNT.
- MEM_WE  output  1  1 = write.
- MEM_ADDR  output  XLEN  word address, bits [1:0] = 0.
- MEM_WDATA  output  XLEN  lane-shifted store data.
- MEM_BE  output  BE_W  byte enables.
- MEM_GNT  input  1  request accepted this cycle.
- MEM_RVALID  input  1  read response valid.
- MEM_RDATA  input  XLEN  read response word.

Behaviour:
- States: IDLE, REQ, WAIT_RSP, FIN.
- Reset (RST_N low, async): state IDLE; all outputs 0, including RD_DATA, MEM_ADDR, MEM_WDATA and MEM_BE.
- Capture: in IDLE with START=1, latch OPCODE, FUNCT3, ADDR, STORE_DATA. START while BUSY is ignored and has no side effect.
- Legal FUNCT3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Illegal opcode or FUNCT3: go to FIN with ERR=1. No MEM_REQ.
- Alignment: halfword requires ADDR[0]=0; word requires ADDR[1:0]=00. See Optional Feature for misaligned handling.
- IDLE->REQ on a legal START.
- REQ: MEM_REQ=1 with MEM_WE, MEM_ADDR, MEM_WDATA and MEM_BE stable until MEM_GNT.
  - GNT on a store: go to FIN.
  - GNT on a load: go to WAIT_RSP.
  - Same-cycle GNT is allowed (zero wait).
- WAIT_RSP: hold until MEM_RVALID. Then register the extended data into RD_DATA and go to FIN. MEM_RVALID outside WAIT_RSP is ignored.
- FIN: DONE=1 for exactly one cycle, then IDLE. BUSY=1 in REQ, WAIT_RSP and FIN.
- Store lanes, off=ADDR[1:0]:
  - Byte: MEM_WDATA = STORE_DATA[7:0] replicated in all 4 lanes; MEM_BE = 4'b0001<<off.
  - Half: low half replicated in both halves; MEM_BE = 4'b0011<<off.
  - Word: MEM_WDATA = STORE_DATA; MEM_BE = 4'b1111.
- Load extract: select byte/half at off from MEM_RDATA. Sign-extend for LB/LH; zero-extend for LBU/LHU. RD_DATA holds its value until the next load completes.
- Latency: load = 4 cycles START-to-DONE (START, REQ, WAIT_RSP, FIN) with immediate GNT and RVALID one cycle after GNT. Store = 3 cycles.
- Reset mid-operation: abort immediately, drop MEM_REQ, no DONE. A late MEM_RVALID after reset is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined: a misaligned legal op goes IDLE->FIN, DONE with ERR=1, no memory access.
- MISALIGN_TRAP_EN undefined: low address bits are truncated to the natural alignment and the access proceeds. ERR is raised only for illegal ops.

Decomposition:
- Shared package lsu_pkg:
  - XLEN constant.
  - State enum lsu_state_t.
  - Opcode constants OP_LOAD and OP_STORE.
  - FUNCT3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_load_align: combinational lane select plus sign/zero extend (inputs FUNCT3, off, word; output XLEN).

Test Plan:
- SW ADDR=0x100, STORE_DATA=0xDEADBEEF, immediate GNT -> MEM_ADDR=0x100, MEM_BE=1111, MEM_WE=1, DONE 3 cycles after START, ERR=0.
- SB ADDR=0x103, STORE_DATA=0x000000A5 -> MEM_ADDR=0x100, MEM_BE=1000, MEM_WDATA=0xA5A5A5A5.
- LB ADDR=0x201, MEM_RDATA=0x0000_80_00 -> RD_DATA=0xFFFFFF80. LBU at the same address -> RD_DATA=0x00000080.
- LH ADDR=0x302, GNT delayed 3 cycles, RVALID 2 cycles later, MEM_RDATA=0x8001_1234 -> MEM_REQ held 4 cycles with stable address, RD_DATA=0xFFFF8001; START pulsed mid-op is ignored.
- LW ADDR=0x105 -> with MISALIGN_TRAP_EN: no MEM_REQ, DONE with ERR=1 after 2 cycles. Without it: MEM_ADDR=0x104, normal load, ERR=0.
- OPCODE=0000011, FUNCT3=011 -> DONE, ERR=1, no MEM_REQ. Also: RST_N low while in WAIT_RSP -> outputs 0 immediately, later RVALID produces no DONE.
